// File: rtl/uartout_arbiter_if.sv
// Requester/transmitter bundle around the uartout arbiter.
// All valid/ready strobes are active low.
interface uartout_arbiter_if #(
  parameter int N = 4
);
  localparam int GW = (N > 1) ? $clog2(N) : 1;

  logic [8*N-1:0] in_data;
  logic [N-1:0]   in_valid_n;
  logic [N-1:0]   in_ready_n;
  logic [7:0]     out_data;
  logic           out_valid_n;
  logic           out_ready_n;
  logic [GW-1:0]  grant_id;
  logic           busy;

  modport master (
    output in_data,
    output in_valid_n,
    output out_ready_n,
    input  in_ready_n,
    input  out_data,
    input  out_valid_n,
    input  grant_id,
    input  busy
  );

  modport slave (
    input  in_data,
    input  in_valid_n,
    input  out_ready_n,
    output in_ready_n,
    output out_data,
    output out_valid_n,
    output grant_id,
    output busy
  );
endinterface

// File: rtl/uartout_arbiter.sv
// Packet-atomic round-robin arbiter feeding one uartout.
// Grant ends on EOL, burst limit or holder idle timeout.
module uartout_arbiter #(
  parameter int         N         = 4,
  parameter logic [7:0] EOL       = 8'h0A,
  parameter int         BURST_MAX = 64,
  parameter int         TIMEOUT   = 1024
) (
  input logic clk,
  input logic rst,
  uartout_arbiter_if.slave bus
);

  localparam int GW = (N > 1) ? $clog2(N) : 1;
  localparam int BW =
    (BURST_MAX > 0) ? $clog2(BURST_MAX + 1) : 1;
  localparam int TW =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [BW-1:0] BLAST =
    BW'((BURST_MAX > 0) ? BURST_MAX - 1 : 0);
  localparam logic [TW-1:0] TLAST =
    TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [GW-1:0] GMAX = GW'(N - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state, state_nx;
  logic [GW-1:0] rr_ptr, rr_nx;
  logic [GW-1:0] gid, gid_nx;
  logic [GW-1:0] pick;
  logic          found;
  logic          busy_r, busy_nx;
  logic [BW-1:0] byte_cnt, byte_nx;
  logic [TW-1:0] idle_cnt, idle_nx;
  logic          hv;
  logic [7:0]    hdata;
  logic          xfer;
  logic          rel;
  int            idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      gid      <= '0;
      busy_r   <= 1'b0;
      byte_cnt <= '0;
      idle_cnt <= '0;
    end else begin
      state    <= state_nx;
      rr_ptr   <= rr_nx;
      gid      <= gid_nx;
      busy_r   <= busy_nx;
      byte_cnt <= byte_nx;
      idle_cnt <= idle_nx;
    end
  end

  // Reverse scan so the smallest offset from rr_ptr wins.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = (int'(rr_ptr) + i) % N;
      if (!bus.in_valid_n[idx]) begin
        pick  = GW'(idx);
        found = 1'b1;
      end
    end
  end

  assign hv    = ~bus.in_valid_n[gid];
  assign hdata = bus.in_data[{gid, 3'b000} +: 8];
  assign xfer  = (state == GRANT) && hv
               && !bus.out_ready_n;

  always_comb begin
    state_nx = state;
    rr_nx    = rr_ptr;
    gid_nx   = gid;
    busy_nx  = busy_r;
    byte_nx  = byte_cnt;
    idle_nx  = idle_cnt;
    rel      = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_nx = GRANT;
          gid_nx   = pick;
          busy_nx  = 1'b1;
          byte_nx  = '0;
          idle_nx  = '0;
        end
      end
      GRANT: begin
        if (xfer) begin
          idle_nx = '0;
          if (byte_cnt != '1)
            byte_nx = byte_cnt + 1'b1;
          if (hdata == EOL)
            rel = 1'b1;
          if (BURST_MAX != 0 && byte_cnt == BLAST)
            rel = 1'b1;
        end else if (!hv) begin
          if (TIMEOUT != 0 && idle_cnt == TLAST)
            rel = 1'b1;
          else if (idle_cnt != '1)
            idle_nx = idle_cnt + 1'b1;
        end else begin
          // Transmitter stalling a valid holder is not idleness.
          idle_nx = '0;
        end
        if (rel) begin
          state_nx = IDLE;
          busy_nx  = 1'b0;
          rr_nx    = (gid == GMAX) ? '0 : gid + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.out_data    = 8'h00;
    bus.out_valid_n = 1'b1;
    bus.in_ready_n  = '1;
    if (state == GRANT) begin
      bus.out_data        = hdata;
      bus.out_valid_n     = bus.in_valid_n[gid];
      bus.in_ready_n[gid] = bus.out_ready_n;
    end
  end

  assign bus.grant_id = gid;
  assign bus.busy     = busy_r;

endmodule
